// File: rtl/lc3b_ir_pipe.sv
// lc3b_ir_pipe: elastic IR buffer between fetch and decode.
// Holds DEPTH {instr, pc} entries and decodes the head entry.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous discard of all entries
//   in_valid/in_ready   fetch-side handshake
//   in_instr, in_pc     incoming instruction and its PC
//   out_valid/out_ready decode-side handshake
//   opcode, dest, src1, src2, ir_10_0
//                       head-word fields (bubble when empty)
//   out_pc              PC of the head entry (0 when empty)
//   count               number of occupied entries
module lc3b_ir_pipe #(
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned PC_WIDTH    = 16,
    parameter int unsigned DEPTH       = 2,
    parameter logic [INSTR_WIDTH-1:0] BUBBLE_WORD = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTR_WIDTH-1:0]       in_instr,
    input  logic [PC_WIDTH-1:0]          in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [3:0]                   opcode,
    output logic [2:0]                   dest,
    output logic [2:0]                   src1,
    output logic [2:0]                   src2,
    output logic [10:0]                  ir_10_0,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    pc;
    } entry_t;

    entry_t         mem [DEPTH];
    logic [PW-1:0]  wp;
    logic [PW-1:0]  rp;
    logic           push;
    logic           pop;

    logic [INSTR_WIDTH-1:0] head_instr;
    logic [PC_WIDTH-1:0]    head_pc;

    // Pointers wrap explicitly so DEPTH need not be a power of 2.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Handshake flags depend on state only; no path from out_ready.
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= '{instr: in_instr, pc: in_pc};
                wp      <= nxt(wp);
            end
            if (pop) begin
                rp <= nxt(rp);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Empty buffer presents a NOP bubble with a zero PC.
    always_comb begin
        head_instr = BUBBLE_WORD;
        head_pc    = '0;
        if (out_valid) begin
            head_instr = mem[rp].instr;
            head_pc    = mem[rp].pc;
        end
    end

    assign opcode  = head_instr[15:12];
    assign dest    = head_instr[11:9];
    assign src1    = head_instr[8:6];
    assign src2    = head_instr[2:0];
    assign ir_10_0 = head_instr[10:0];
    assign out_pc  = head_pc;

endmodule

// File: tb/tb_lc3b_ir_pipe.sv
// tb_lc3b_ir_pipe: drives DEPTH=2 and DEPTH=3 buffers in lockstep
// and compares both against queue-based reference models.
module tb_lc3b_ir_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_instr = '0;
    logic [15:0] in_pc = '0;

    logic        r2, v2, r3, v3;
    logic [3:0]  op2, op3;
    logic [2:0]  dst2, sa2, sb2, dst3, sa3, sb3;
    logic [10:0] ir2, ir3;
    logic [15:0] pc2, pc3;
    logic [1:0]  cnt2, cnt3;

    logic [31:0] q2[$];
    logic [31:0] q3[$];

    int n_vec = 0;
    int errs  = 0;

    always #5 clk = ~clk;

    lc3b_ir_pipe #(.DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r2),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(v2), .out_ready(out_ready),
        .opcode(op2), .dest(dst2), .src1(sa2), .src2(sb2),
        .ir_10_0(ir2), .out_pc(pc2), .count(cnt2)
    );

    lc3b_ir_pipe #(.DEPTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r3),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(v3), .out_ready(out_ready),
        .opcode(op3), .dest(dst3), .src1(sa3), .src2(sb3),
        .ir_10_0(ir3), .out_pc(pc3), .count(cnt3)
    );

    // Expected observable state of a FIFO of capacity d.
    function automatic logic [43:0] model_vec(
        input logic [31:0] q[$], input int d);
        logic [15:0] w;
        logic [15:0] p;
        w = 16'h0000;
        p = 16'h0000;
        if (q.size() != 0) begin
            w = q[0][31:16];
            p = q[0][15:0];
        end
        return {w[15:12], w[11:9], w[8:6], w[2:0], w[10:0], p,
                2'(q.size()), q.size() != 0, q.size() < d};
    endfunction

    function automatic logic [87:0] act_all();
        return {op2, dst2, sa2, sb2, ir2, pc2, cnt2, v2, r2,
                op3, dst3, sa3, sb3, ir3, pc3, cnt3, v3, r3};
    endfunction

    function automatic logic [87:0] exp_all();
        return {model_vec(q2, 2), model_vec(q3, 3)};
    endfunction

    // Advance models with the current inputs, then clock the DUTs.
    task automatic tick();
        bit pu;
        bit po;
        if (!rst_n || flush) begin
            q2.delete();
            q3.delete();
        end else begin
            po = q2.size() != 0 && out_ready;
            pu = in_valid && q2.size() < 2;
            if (po) void'(q2.pop_front());
            if (pu) q2.push_back({in_instr, in_pc});
            po = q3.size() != 0 && out_ready;
            pu = in_valid && q3.size() < 3;
            if (po) void'(q3.pop_front());
            if (pu) q3.push_back({in_instr, in_pc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({r2, v2, op2, pc2, cnt2, r3, v3, op3, pc3, cnt3}
            !== {1'b1, 1'b0, 4'h0, 16'h0, 2'd0,
                 1'b1, 1'b0, 4'h0, 16'h0, 2'd0}) begin
            errs++;
            $display("FAIL reset_hold: got %h", act_all());
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (act_all() !== exp_all()) begin
            errs++;
            $display("FAIL reset_idle: got %h want %h",
                     act_all(), exp_all());
        end
    endtask

    task automatic test_single_push();
        in_valid = 1'b1;
        in_instr = 16'h1283;
        in_pc    = 16'h3000;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({v2, op2, dst2, sa2, sb2, ir2, pc2}
            !== {1'b1, 4'h1, 3'd1, 3'd2, 3'd3, 11'h283, 16'h3000})
        begin
            errs++;
            $display("FAIL single_fields: got %h", act_all());
        end
        n_vec++;
        if (act_all() !== exp_all()) begin
            errs++;
            $display("FAIL single_model: got %h want %h",
                     act_all(), exp_all());
        end
    endtask

    task automatic test_fill();
        logic [15:0] words [3];
        words[0] = 16'h1283;
        words[1] = 16'h5A46;
        words[2] = 16'h0E01;
        drain();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_instr = words[i];
            in_pc    = 16'h3000 + 16'(2 * i);
            tick();
        end
        in_valid = 1'b0;
        n_vec++;
        if ({cnt2, r2, op2, dst2[2], ir2}
            !== {2'd2, 1'b0, 16'h1283}) begin
            errs++;
            $display("FAIL fill_full: got %h", act_all());
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if ({v2, op2, dst2[2], ir2, pc2}
            !== {1'b1, 16'h5A46, 16'h3002}) begin
            errs++;
            $display("FAIL fill_second: got %h", act_all());
        end
        tick();
        out_ready = 1'b0;
        n_vec++;
        if (act_all() !== exp_all() || v2 !== 1'b0) begin
            errs++;
            $display("FAIL fill_drained: got %h want %h",
                     act_all(), exp_all());
        end
    endtask

    task automatic test_back_to_back();
        drain();
        in_valid = 1'b1;
        in_instr = 16'h2A7F;
        in_pc    = 16'h4000;
        tick();
        out_ready = 1'b1;
        in_instr  = 16'h6C85;
        in_pc     = 16'h4002;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_vec++;
        if ({cnt2, op2, dst2[2], ir2, pc2, cnt3}
            !== {2'd1, 16'h6C85, 16'h4002, 2'd1}) begin
            errs++;
            $display("FAIL b2b_advance: got %h", act_all());
        end
        n_vec++;
        if (act_all() !== exp_all()) begin
            errs++;
            $display("FAIL b2b_model: got %h want %h",
                     act_all(), exp_all());
        end
    endtask

    task automatic test_wrap();
        logic [15:0] words [10];
        int sent = 0;
        int rcvd = 0;
        int cyc  = 0;
        bit max_ok = 1'b1;
        bit order_ok = 1'b1;
        drain();
        for (int i = 0; i < 10; i++) begin
            words[i] = 16'($urandom);
        end
        out_ready = 1'b1;
        while (rcvd < 10 && cyc < 80) begin
            in_valid = sent < 10;
            in_instr = (sent < 10) ? words[sent] : 16'h0;
            in_pc    = 16'h5000 + 16'(2 * sent);
            if (v3 && out_ready) begin
                if ({op3, dst3[2], ir3, pc3}
                    !== {words[rcvd], 16'h5000 + 16'(2 * rcvd)})
                    order_ok = 1'b0;
                rcvd++;
            end
            if (in_valid && q3.size() < 3) sent++;
            tick();
            if (cnt3 > 2'd3 || act_all() !== exp_all())
                max_ok = 1'b0;
            out_ready = ~out_ready;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_vec++;
        if (rcvd != 10 || !order_ok) begin
            errs++;
            $display("FAIL wrap_order: got %0d ok=%0d want 10 ok=1",
                     rcvd, order_ok);
        end
        n_vec++;
        if (!max_ok) begin
            errs++;
            $display("FAIL wrap_state: got %h want %h",
                     act_all(), exp_all());
        end
    endtask

    task automatic test_flush();
        drain();
        in_valid = 1'b1;
        in_instr = 16'h1283;
        tick();
        in_instr = 16'h5A46;
        tick();
        flush    = 1'b1;
        in_instr = 16'hF025;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if ({cnt2, v2, op2, ir2, pc2, cnt3, v3}
            !== {2'd0, 1'b0, 4'h0, 11'h0, 16'h0, 2'd0, 1'b0}) begin
            errs++;
            $display("FAIL flush_push: got %h", act_all());
        end
        n_vec++;
        if (act_all() !== exp_all()) begin
            errs++;
            $display("FAIL flush_model: got %h want %h",
                     act_all(), exp_all());
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        in_instr = 16'h3BCD;
        in_pc    = 16'h6000;
        tick();
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        q2.delete();
        q3.delete();
        #1;
        n_vec++;
        if (act_all() !== exp_all() || v2 !== 1'b0) begin
            errs++;
            $display("FAIL async_reset: got %h want %h",
                     act_all(), exp_all());
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 15) == 0);
            in_instr  = 16'($urandom);
            in_pc     = 16'($urandom);
            tick();
            n_vec++;
            if (act_all() !== exp_all()) begin
                errs++;
                if (bad < 5)
                    $display("FAIL random[%0d]: got %h want %h",
                             i, act_all(), exp_all());
                bad++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, errs);
        $finish;
    end

endmodule
